// File: rtl/game_pkg.sv
// Shared encodings for the game FSM and the life manager.
package game_pkg;

  localparam int unsigned GAME_STATE_W = 2;

  localparam logic [GAME_STATE_W-1:0] GAME_INITIAL = 2'd0;
  localparam logic [GAME_STATE_W-1:0] GAME_PLAYING = 2'd1;
  localparam logic [GAME_STATE_W-1:0] GAME_OVER    = 2'd2;

  typedef enum logic [1:0] {
    LIFE_ALIVE  = 2'd0,
    LIFE_INVULN = 2'd1,
    LIFE_DEAD   = 2'd2
  } life_state_t;

endpackage

// File: rtl/life_manager_if.sv
// Game-state/collision inputs and HUD outputs of the life manager.
interface life_manager_if
  import game_pkg::*;
#(
  parameter int unsigned LIFE_W = 2
) ();

  logic [GAME_STATE_W-1:0] state;
  logic                    frame_tick;
  logic                    hit;
  logic [LIFE_W-1:0]       lives;
  logic                    invincible;
  logic                    blink;
  logic                    game_over;

  modport master (
    output state, frame_tick, hit,
    input  lives, invincible, blink, game_over
  );

  modport slave (
    input  state, frame_tick, hit,
    output lives, invincible, blink, game_over
  );

endinterface

// File: rtl/frame_timer.sv
// Loadable frame down-counter; done_c flags the tick on which the count is 1.
module frame_timer #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  input  logic         en,
  output logic         done_c
);

  logic [W-1:0] count_q, count_d;

  // Clear beats load beats decrement; the count never wraps below zero.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (tick && en && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_c = tick && (count_q == W'(1));

endmodule

// File: rtl/life_manager.sv
// Life counter, post-hit invulnerability window and game_over for the game FSM.
// Optional sprite blink during invulnerability when BLINK_EN is defined.
module life_manager
  import game_pkg::*;
#(
  parameter int unsigned MAX_LIVES    = 3,
  parameter int unsigned LIFE_W       = 2,
  parameter int unsigned INV_FRAMES   = 60,
  parameter int unsigned INV_W        = 6,
  parameter int unsigned BLINK_FRAMES = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  life_manager_if.slave  bus
);

  if (MAX_LIVES < 1 || MAX_LIVES > (2**LIFE_W) - 1 ||
      INV_FRAMES < 1 || INV_FRAMES > (2**INV_W) - 1 || BLINK_FRAMES < 1) begin : g_param_check
    $error("life_manager: illegal parameter set");
  end

  life_state_t       state_q, state_d;
  logic [LIFE_W-1:0] lives_q, lives_d;
  logic              inv_q, inv_d;
  logic              over_q, over_d;

  logic inv_clr, inv_load, inv_en, inv_done_c;

  frame_timer #(.W(INV_W)) u_inv_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (inv_clr),
    .load     (inv_load),
    .load_val (INV_W'(INV_FRAMES)),
    .tick     (bus.frame_tick),
    .en       (inv_en),
    .done_c   (inv_done_c)
  );

`ifdef BLINK_EN
  localparam int unsigned BLK_W = $clog2(BLINK_FRAMES + 1);

  logic blink_q, blink_d;
  logic blk_clr, blk_load, blk_en, blk_done_c;

  frame_timer #(.W(BLK_W)) u_blink_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (blk_clr),
    .load     (blk_load),
    .load_val (BLK_W'(BLINK_FRAMES)),
    .tick     (bus.frame_tick),
    .en       (blk_en),
    .done_c   (blk_done_c)
  );
`endif

  // Next-state: INITIAL rearms everything, PLAYING advances only on frame ticks, OVER holds.
  always_comb begin
    state_d  = state_q;
    lives_d  = lives_q;
    inv_d    = inv_q;
    over_d   = over_q;
    inv_clr  = 1'b0;
    inv_load = 1'b0;
    inv_en   = 1'b0;
`ifdef BLINK_EN
    blink_d  = blink_q;
    blk_clr  = 1'b0;
    blk_load = 1'b0;
    blk_en   = 1'b0;
`endif
    case (bus.state)
      GAME_INITIAL: begin
        state_d = LIFE_ALIVE;
        lives_d = LIFE_W'(MAX_LIVES);
        inv_d   = 1'b0;
        over_d  = 1'b0;
        inv_clr = 1'b1;
`ifdef BLINK_EN
        blink_d = 1'b0;
        blk_clr = 1'b1;
`endif
      end
      GAME_PLAYING: begin
        if (bus.frame_tick) begin
          case (state_q)
            LIFE_ALIVE: begin
              if (bus.hit && (lives_q > LIFE_W'(1))) begin
                lives_d  = lives_q - LIFE_W'(1);
                inv_load = 1'b1;
                inv_d    = 1'b1;
                state_d  = LIFE_INVULN;
`ifdef BLINK_EN
                blink_d  = 1'b1;
                blk_load = 1'b1;
`endif
              end else if (bus.hit) begin
                lives_d = '0;
                over_d  = 1'b1;
                state_d = LIFE_DEAD;
              end
            end
            LIFE_INVULN: begin
              inv_en = 1'b1;
              if (inv_done_c) begin
                inv_d   = 1'b0;
                state_d = LIFE_ALIVE;
`ifdef BLINK_EN
                blink_d = 1'b0;
                blk_clr = 1'b1;
`endif
              end else begin
`ifdef BLINK_EN
                blk_en = 1'b1;
                if (blk_done_c) begin
                  blink_d  = ~blink_q;
                  blk_load = 1'b1;
                end
`endif
              end
            end
            LIFE_DEAD: begin
              lives_d = '0;
              over_d  = 1'b1;
            end
            default: state_d = LIFE_ALIVE;
          endcase
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LIFE_ALIVE;
      lives_q <= LIFE_W'(MAX_LIVES);
      inv_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      inv_q   <= inv_d;
      over_q  <= over_d;
    end
  end

`ifdef BLINK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
    end
  end

  assign bus.blink = blink_q;
`else
  assign bus.blink = 1'b0;
`endif

  assign bus.lives      = lives_q;
  assign bus.invincible = inv_q;
  assign bus.game_over  = over_q;

endmodule

// File: tb/tb_life_manager.sv
// Directed bench for life_manager with a lives/window model checked every cycle.
module tb_life_manager;
  import game_pkg::*;

  localparam int unsigned MAXL = 3;
  localparam int unsigned LW   = 2;
  localparam int unsigned BF   = 2;
`ifdef BLINK_EN
  localparam int unsigned INV  = 8;
  localparam int          BLK  = 1;
`else
  localparam int unsigned INV  = 4;
  localparam int          BLK  = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  life_manager_if #(.LIFE_W(LW)) bus ();

  life_manager #(
    .MAX_LIVES    (MAXL),
    .LIFE_W       (LW),
    .INV_FRAMES   (INV),
    .INV_W        (6),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: lives left, frames of protection remaining, frames elapsed since the hit.
  int m_lives = MAXL;
  int m_left  = 0;
  int m_since = 0;
  int m_over  = 0;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_blink();
    if (BLK == 0 || m_left == 0) return 0;
    return (((m_since / int'(BF)) % 2) == 0) ? 1 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus.state == GAME_INITIAL) begin
      m_lives = MAXL; m_left = 0; m_since = 0; m_over = 0;
    end else if (bus.state == GAME_PLAYING && bus.frame_tick) begin
      if (m_over == 0) begin
        if (m_left > 0) begin
          m_left--;
          m_since++;
        end else if (bus.hit) begin
          if (m_lives > 1) begin
            m_lives--; m_left = INV; m_since = 0;
          end else begin
            m_lives = 0; m_over = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("m_lives", int'(bus.lives), m_lives);
      check("m_invincible", int'(bus.invincible), (m_left > 0) ? 1 : 0);
      check("m_blink", int'(bus.blink), exp_blink());
      check("m_game_over", int'(bus.game_over), m_over);
    end
  end

  task automatic expect_out(input string nm, input int lv, input int inv, input int ov);
    check({nm, "_lives"}, int'(bus.lives), lv);
    check({nm, "_inv"}, int'(bus.invincible), inv);
    check({nm, "_over"}, int'(bus.game_over), ov);
  endtask

  // Called at a falling edge; presents one frame tick across the next rising edge.
  task automatic do_tick(input logic h);
    bus.frame_tick = 1'b1;
    bus.hit        = h;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    bus.hit        = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    pat = 8'b0011_0011;
    rst_n          = 1'b0;
    bus.state      = GAME_INITIAL;
    bus.frame_tick = 1'b0;
    bus.hit        = 1'b0;
    #12;
    expect_out("reset", 3, 0, 0);
    check("reset_blink", int'(bus.blink), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_out("initial", 3, 0, 0);

    bus.state = GAME_PLAYING;
    bus.hit   = 1'b1;
    repeat (10) @(negedge clk);
    bus.hit = 1'b0;
    expect_out("no_tick", 3, 0, 0);

    do_tick(1'b1);
    expect_out("hit1", 2, 1, 0);
    check("hit1_blink", int'(bus.blink), BLK);

    for (int i = 1; i <= int'(INV); i++) begin
      bus.hit = 1'b1;
      @(negedge clk);
      do_tick(1'b1);
      expect_out("window", 2, (i < int'(INV)) ? 1 : 0, 0);
      check("window_blink", int'(bus.blink), (BLK != 0 && i < int'(INV)) ? int'(pat[i]) : 0);
    end

    do_tick(1'b1);
    expect_out("hit_after_window", 1, 1, 0);

    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    expect_out("async_reset", 3, 0, 0);
    check("async_reset_blink", int'(bus.blink), 0);
    #1 rst_n = 1'b1;
    @(negedge clk);

    do_tick(1'b1);
    expect_out("spaced1", 2, 1, 0);
    repeat (INV) do_tick(1'b0);
    expect_out("spaced1_end", 2, 0, 0);
    do_tick(1'b1);
    expect_out("spaced2", 1, 1, 0);
    repeat (INV) do_tick(1'b0);
    do_tick(1'b1);
    expect_out("spaced3", 0, 0, 1);
    repeat (3) do_tick(1'b1);
    expect_out("dead_playing", 0, 0, 1);
    bus.state = GAME_OVER;
    repeat (3) do_tick(1'b1);
    expect_out("dead_over", 0, 0, 1);

    bus.state = GAME_INITIAL;
    @(negedge clk);
    expect_out("rearm", 3, 0, 0);
    bus.state = GAME_PLAYING;
    do_tick(1'b1);
    expect_out("rearm_hit", 2, 1, 0);

    bus.state = GAME_OVER;
    repeat (INV + 2) do_tick(1'b1);
    expect_out("over_freeze", 2, 1, 0);
    bus.state = GAME_PLAYING;
    repeat (INV) do_tick(1'b0);
    expect_out("resume_end", 2, 0, 0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
